// File: rtl/systolic_2x2_feeder_if.sv
// Bundle of the feeder's upstream pair handshake, skewed array stream and result handshake.
// The feeder takes the slave view; whatever drives pairs and models the array takes master.
interface systolic_2x2_feeder_if #(
  parameter int data_width = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4*data_width-1:0]   a_mat;
  logic [4*data_width-1:0]   b_mat;

  logic                      arr_enable;
  logic                      arr_clear;
  logic [data_width-1:0]     arr_a0;
  logic [data_width-1:0]     arr_a1;
  logic [data_width-1:0]     arr_b0;
  logic [data_width-1:0]     arr_b1;
  logic [2*data_width-1:0]   arr_c00;
  logic [2*data_width-1:0]   arr_c01;
  logic [2*data_width-1:0]   arr_c10;
  logic [2*data_width-1:0]   arr_c11;
  logic                      arr_done;

  logic                      out_valid;
  logic                      out_ready;
  logic [8*data_width-1:0]   c_mat;
  logic                      err;
  logic                      busy;

  modport slave (
    input  in_valid, a_mat, b_mat,
    input  arr_c00, arr_c01, arr_c10, arr_c11, arr_done,
    input  out_ready,
    output in_ready, arr_enable, arr_clear, arr_a0, arr_a1, arr_b0, arr_b1,
    output out_valid, c_mat, err, busy
  );

  modport master (
    output in_valid, a_mat, b_mat,
    output arr_c00, arr_c01, arr_c10, arr_c11, arr_done,
    output out_ready,
    input  in_ready, arr_enable, arr_clear, arr_a0, arr_a1, arr_b0, arr_b1,
    input  out_valid, c_mat, err, busy
  );
endinterface

// File: rtl/systolic_2x2_feeder.sv
// Feeds one 2x2 A/B pair into a systolic array with row/column skew and returns the result.
// Result earliest 8 cycles after accept plus array done delay; result held until out_ready.
module systolic_2x2_feeder #(
  parameter int data_width     = 8,
  parameter int timeout_cycles = 16
) (
  input logic                clk,
  input logic                rst,
  systolic_2x2_feeder_if.slave bus
);
  localparam int dw = data_width;
  localparam int cw = $clog2(timeout_cycles + 1);
  localparam logic [cw-1:0] cnt_last = cw'(timeout_cycles - 1);
  localparam logic [cw-1:0] cnt_one  = cw'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, PAD, WAIT, HOLD} state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [cw-1:0]    wait_cnt;
  logic [4*dw-1:0]  a_reg;
  logic [4*dw-1:0]  b_reg;

  logic             in_ready_q;
  logic             busy_q;
  logic             arr_enable_q;
  logic             arr_clear_q;
  logic             out_valid_q;
  logic             err_q;
  logic [dw-1:0]    a0_q, a1_q, b0_q, b1_q;
  logic [8*dw-1:0]  c_mat_q;

  logic [dw-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
  assign a00 = a_reg[0*dw +: dw];
  assign a01 = a_reg[1*dw +: dw];
  assign a10 = a_reg[2*dw +: dw];
  assign a11 = a_reg[3*dw +: dw];
  assign b00 = b_reg[0*dw +: dw];
  assign b01 = b_reg[1*dw +: dw];
  assign b10 = b_reg[2*dw +: dw];
  assign b11 = b_reg[3*dw +: dw];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      wait_cnt     <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      arr_enable_q <= 1'b0;
      arr_clear_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      a0_q         <= '0;
      a1_q         <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      c_mat_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg       <= bus.a_mat;
            b_reg       <= bus.b_mat;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            arr_clear_q <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          arr_clear_q  <= 1'b0;
          arr_enable_q <= 1'b1;
          a0_q         <= a00;
          b0_q         <= b00;
          a1_q         <= '0;
          b1_q         <= '0;
          phase        <= 2'd0;
          state        <= FEED;
        end
        // Row 1 / column 1 lag row 0 / column 0 by one step.
        FEED: begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: begin
              a0_q <= a01;
              b0_q <= b10;
              a1_q <= a10;
              b1_q <= b01;
            end
            2'd1: begin
              a0_q <= '0;
              b0_q <= '0;
              a1_q <= a11;
              b1_q <= b11;
            end
            default: begin
              a0_q  <= '0;
              b0_q  <= '0;
              a1_q  <= '0;
              b1_q  <= '0;
              phase <= 2'd0;
              state <= PAD;
            end
          endcase
        end
        PAD: begin
          if (phase == 2'd2) begin
            phase    <= 2'd0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            phase <= phase + 2'd1;
          end
        end
        // A done on the expiring cycle still counts as a real result.
        WAIT: begin
          if (bus.arr_done) begin
            c_mat_q      <= {bus.arr_c11, bus.arr_c10, bus.arr_c01, bus.arr_c00};
            err_q        <= 1'b0;
            out_valid_q  <= 1'b1;
            arr_enable_q <= 1'b0;
            state        <= HOLD;
          end else if (wait_cnt == cnt_last) begin
            c_mat_q      <= '0;
            err_q        <= 1'b1;
            out_valid_q  <= 1'b1;
            arr_enable_q <= 1'b0;
            state        <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + cnt_one;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.arr_enable = arr_enable_q;
  assign bus.arr_clear  = arr_clear_q;
  assign bus.arr_a0     = a0_q;
  assign bus.arr_a1     = a1_q;
  assign bus.arr_b0     = b0_q;
  assign bus.arr_b1     = b1_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.c_mat      = c_mat_q;
endmodule
